// File: rtl/bound_flasher_ctrl.sv
// Command sequencer for the 16-lamp bound-flasher shift datapath.
// Keeps its own lit-lamp count so the datapath's combinational lamp output is never read back.
module bound_flasher_ctrl #(
  parameter int unsigned NLAMP = 16,
  parameter int unsigned P1    = 6,
  parameter int unsigned P2    = 11,
  parameter int unsigned MID   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flick,
  output logic [1:0] cmd,
  output logic [4:0] level,
  output logic [2:0] state,
  output logic       busy
);

  // state | meaning
  // IDLE  | datapath held clear, waiting for flick
  // UP1   | light lamps up to P1
  // DN1   | extinguish down to 0
  // UP2   | light up to P2, kickback to DN1 on flick at P1/P2
  // DN2   | extinguish down to MID
  // UP3   | light up to NLAMP, kickback to DN2 on flick at P1/P2
  // DN3   | extinguish down to 0, restart on flick at the last step
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] UP1  = 3'd1;
  localparam logic [2:0] DN1  = 3'd2;
  localparam logic [2:0] UP2  = 3'd3;
  localparam logic [2:0] DN2  = 3'd4;
  localparam logic [2:0] UP3  = 3'd5;
  localparam logic [2:0] DN3  = 3'd6;

  localparam logic [1:0] CMD_CLR = 2'd0;
  localparam logic [1:0] CMD_ONE = 2'd1;
  localparam logic [1:0] CMD_ZER = 2'd2;

  localparam logic [4:0] P1_L    = 5'(P1);
  localparam logic [4:0] P2_L    = 5'(P2);
  localparam logic [4:0] MID_L   = 5'(MID);
  localparam logic [4:0] NLAMP_L = 5'(NLAMP);

  logic [2:0] state_nx;
  logic [4:0] level_nx;
  logic       kick;

  always_comb begin
    cmd = CMD_CLR;
    case (state)
      UP1, UP2, UP3: cmd = CMD_ONE;
      DN1, DN2, DN3: cmd = CMD_ZER;
      default:       cmd = CMD_CLR;
    endcase
  end

  assign busy = (state != IDLE);

  // Mirror of the datapath register after this edge's command is applied.
  always_comb begin
    level_nx = 5'd0;
    case (cmd)
      CMD_ONE: level_nx = level + 5'd1;
      CMD_ZER: level_nx = level - 5'd1;
      default: level_nx = 5'd0;
    endcase
  end

  assign kick = flick && ((level_nx == P1_L) || (level_nx == P2_L));

  // Kickback is tested ahead of the segment target so UP2 at P2 with flick goes to DN1.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (flick) state_nx = UP1;
      UP1:  if (level_nx == P1_L) state_nx = DN1;
      DN1:  if (level_nx == 5'd0) state_nx = UP2;
      UP2: begin
        if (kick)                    state_nx = DN1;
        else if (level_nx == P2_L)   state_nx = DN2;
      end
      DN2:  if (level_nx == MID_L) state_nx = UP3;
      UP3: begin
        if (kick)                    state_nx = DN2;
        else if (level_nx == NLAMP_L) state_nx = DN3;
      end
      DN3:  if (level_nx == 5'd0) state_nx = flick ? UP1 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      level <= 5'd0;
    end else begin
      state <= state_nx;
      level <= level_nx;
    end
  end

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl with a behavioural model of the shift datapath.
module tb_bound_flasher_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UP1  = 3'd1;
  localparam logic [2:0] S_DN1  = 3'd2;
  localparam logic [2:0] S_UP2  = 3'd3;
  localparam logic [2:0] S_DN2  = 3'd4;
  localparam logic [2:0] S_UP3  = 3'd5;
  localparam logic [2:0] S_DN3  = 3'd6;

  logic       clk = 1'b0;
  logic       rst;
  logic       flick;
  logic [1:0] cmd;
  logic [4:0] level;
  logic [2:0] state;
  logic       busy;
  logic [15:0] dp_reg;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  typedef struct {
    int          ncyc;
    logic        flick;
    logic [2:0]  st;
    logic [4:0]  lvl;
    logic [1:0]  cmd;
    logic        busy;
    logic [15:0] pat;
  } vec_t;

  vec_t tbl[7];

  bound_flasher_ctrl #(.NLAMP(16), .P1(6), .P2(11), .MID(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flick (flick),
    .cmd   (cmd),
    .level (level),
    .state (state),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Shift datapath: 1 lights the next lamp from bit 0 upward, 2 drops the top lamp, 0 clears.
  always @(posedge clk) begin
    if (rst) dp_reg <= 16'h0000;
    else begin
      case (cmd)
        2'd1:    dp_reg <= {dp_reg[14:0], 1'b1};
        2'd2:    dp_reg <= dp_reg >> 1;
        default: dp_reg <= 16'h0000;
      endcase
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] st, input logic [4:0] lvl,
                         input logic [1:0] c, input logic b, input logic [15:0] pat);
    chk({name, "_state"}, int'(state), int'(st));
    chk({name, "_level"}, int'(level), int'(lvl));
    chk({name, "_cmd"},   int'(cmd),   int'(c));
    chk({name, "_busy"},  int'(busy),  int'(b));
    chk({name, "_dp"},    int'(dp_reg), int'(pat));
  endtask

  task automatic pulse();
    flick = 1'b1;
    step(1);
    flick = 1'b0;
  endtask

  task automatic do_reset();
    flick = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1,  1'b1, S_UP1,  5'd0,  2'd1, 1'b1, 16'h0000};
    tbl[1] = '{6,  1'b0, S_DN1,  5'd6,  2'd2, 1'b1, 16'h003F};
    tbl[2] = '{6,  1'b0, S_UP2,  5'd0,  2'd1, 1'b1, 16'h0000};
    tbl[3] = '{11, 1'b0, S_DN2,  5'd11, 2'd2, 1'b1, 16'h07FF};
    tbl[4] = '{6,  1'b0, S_UP3,  5'd5,  2'd1, 1'b1, 16'h001F};
    tbl[5] = '{11, 1'b0, S_DN3,  5'd16, 2'd2, 1'b1, 16'hFFFF};
    tbl[6] = '{16, 1'b0, S_IDLE, 5'd0,  2'd0, 1'b0, 16'h0000};

    rst = 1'b1;
    flick = 1'b0;
    step(2);
    chk_all("reset", S_IDLE, 5'd0, 2'd0, 1'b0, 16'h0000);
    rst = 1'b0;
    step(3);
    chk_all("idle_wait", S_IDLE, 5'd0, 2'd0, 1'b0, 16'h0000);

    // Nominal single-pulse sequence, segment by segment.
    busy_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      flick = tbl[i].flick;
      step(tbl[i].ncyc);
      flick = 1'b0;
      chk_all($sformatf("nominal_seg%0d", i), tbl[i].st, tbl[i].lvl, tbl[i].cmd,
              tbl[i].busy, tbl[i].pat);
    end
    chk("nominal_busy_cycles", busy_cnt, 56);

    // Kickback in UP2 on the 5->6 step.
    do_reset();
    pulse();
    step(12);
    step(5);
    chk_all("kb_up2_pre", S_UP2, 5'd5, 2'd1, 1'b1, 16'h001F);
    flick = 1'b1;
    step(1);
    flick = 1'b0;
    chk_all("kb_up2_p1", S_DN1, 5'd6, 2'd2, 1'b1, 16'h003F);
    step(6);
    chk_all("kb_up2_floor", S_UP2, 5'd0, 2'd1, 1'b1, 16'h0000);
    step(11);
    chk_all("kb_up2_rerun", S_DN2, 5'd11, 2'd2, 1'b1, 16'h07FF);

    // Kickback in UP3 on the 10->11 step goes back to DN2.
    do_reset();
    pulse();
    step(29);
    step(5);
    chk_all("kb_up3_pre", S_UP3, 5'd10, 2'd1, 1'b1, 16'h03FF);
    flick = 1'b1;
    step(1);
    flick = 1'b0;
    chk_all("kb_up3_p2", S_DN2, 5'd11, 2'd2, 1'b1, 16'h07FF);
    step(6);
    chk_all("kb_up3_mid", S_UP3, 5'd5, 2'd1, 1'b1, 16'h001F);
    step(11);
    chk_all("kb_up3_rerun", S_DN3, 5'd16, 2'd2, 1'b1, 16'hFFFF);

    // Priority: UP2 reaching P2 with flick goes to DN1, not DN2.
    do_reset();
    pulse();
    step(12);
    step(10);
    flick = 1'b1;
    step(1);
    flick = 1'b0;
    chk_all("prio_up2_p2", S_DN1, 5'd11, 2'd2, 1'b1, 16'h07FF);
    step(11);
    chk_all("prio_up2_floor", S_UP2, 5'd0, 2'd1, 1'b1, 16'h0000);

    // Flick held high: UP1, DN1, then UP2/DN1 loop between 0 and 6.
    do_reset();
    flick = 1'b1;
    step(1);
    chk_all("hold_start", S_UP1, 5'd0, 2'd1, 1'b1, 16'h0000);
    step(6);
    chk_all("hold_dn1", S_DN1, 5'd6, 2'd2, 1'b1, 16'h003F);
    step(6);
    chk_all("hold_up2", S_UP2, 5'd0, 2'd1, 1'b1, 16'h0000);
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 6; j++) begin
        step(1);
        n_checks++;
        if (level > 5'd6 || cmd == 2'd0 || !busy) begin
          n_fail++;
          $display("FAIL hold_loop: level %0d cmd %0d busy %0d, required level<=6 cmd!=0 busy=1",
                   level, cmd, busy);
        end
      end
      if (it % 2 == 0) chk_all($sformatf("hold_iter%0d", it), S_DN1, 5'd6, 2'd2, 1'b1, 16'h003F);
      else             chk_all($sformatf("hold_iter%0d", it), S_UP2, 5'd0, 2'd1, 1'b1, 16'h0000);
    end

    // Restart from the last DN3 step with flick high.
    do_reset();
    pulse();
    step(40);
    step(15);
    chk_all("restart_pre", S_DN3, 5'd1, 2'd2, 1'b1, 16'h0001);
    flick = 1'b1;
    step(1);
    flick = 1'b0;
    chk_all("restart_hi", S_UP1, 5'd0, 2'd1, 1'b1, 16'h0000);
    step(6);
    chk_all("restart_dn1", S_DN1, 5'd6, 2'd2, 1'b1, 16'h003F);

    // Same point with flick low ends in IDLE.
    do_reset();
    pulse();
    step(55);
    step(1);
    chk_all("restart_lo", S_IDLE, 5'd0, 2'd0, 1'b0, 16'h0000);

    // Reset held two cycles in the middle of UP3.
    do_reset();
    pulse();
    step(29);
    step(3);
    chk_all("rst_mid_pre", S_UP3, 5'd8, 2'd1, 1'b1, 16'h00FF);
    rst = 1'b1;
    step(1);
    chk_all("rst_mid_1", S_IDLE, 5'd0, 2'd0, 1'b0, 16'h0000);
    step(1);
    chk_all("rst_mid_2", S_IDLE, 5'd0, 2'd0, 1'b0, 16'h0000);
    rst = 1'b0;
    step(1);
    chk_all("rst_mid_post", S_IDLE, 5'd0, 2'd0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bound_flasher_ctrl.md
# bound_flasher_ctrl

Sequencing controller for the 16-lamp bound-flasher shift datapath. It drives the datapath's 2-bit command input (0 = clear, 1 = shift-in-one / light next lamp, 2 = shift-in-zero / extinguish top lamp) one command per clock. The command sequence produces the up/down lamp pattern, with kickback on a `flick` request. It keeps an internal lit-lamp count that mirrors the datapath register, so it never reads `lamp` back; the datapath's `lamp` output is combinational on `in`, and reading it back would form a loop.

## Interface
- `NLAMP`, 16: lamp count; equals the datapath width.
- `P1`, 6: first peak, as a lit count (lamps 0..5); also the low kickback point.
- `P2`, 11: second peak, as a lit count (lamps 0..10); also the high kickback point.
- `MID`, 5: floor of the second descent, as a lit count.
- `clk`  in  1  rising-edge clock, shared with the datapath.
- `rst`  in  1  synchronous, active-high reset. The datapath's `rst_n` is driven by `~rst` at top level.
- `flick`  in  1  level-sensitive start/kickback request, synchronous to `clk`.
- `cmd`  out  2  command to the datapath `in` port.
- `level`  out  5  number of lit lamps in the datapath register, 0..NLAMP.
- `state`  out  3  current FSM state encoding, for debug.
- `busy`  out  1  high when `state` != IDLE.

## Operation
- Registered `state` and `level`. `cmd` and `busy` are decoded combinationally from `state` only (Moore).
- States and commands:
  - IDLE: cmd=0
  - UP1: cmd=1, target P1
  - DN1: cmd=2, target 0
  - UP2: cmd=1, target P2
  - DN2: cmd=2, target MID
  - UP3: cmd=1, target NLAMP
  - DN3: cmd=2, target 0
- Level update at each edge: cmd=1 → level+1; cmd=2 → level-1; cmd=0 → level=0. The level always equals popcount of the datapath register, and the lit lamps are the contiguous bits [level-1:0].
- Transitions are evaluated on the post-edge value n (n = level±1):
  - IDLE: `flick`=1 → UP1; otherwise stay.
  - UP1: n==P1 → DN1.
  - DN1: n==0 → UP2.
  - UP2: `flick`=1 and (n==P1 or n==P2) → DN1 (kickback). Else n==P2 → DN2.
  - DN2: n==MID → UP3.
  - UP3: `flick`=1 and (n==P1 or n==P2) → DN2 (kickback). Else n==NLAMP → DN3.
  - DN3: n==0 → UP1 if `flick`=1, else IDLE.
- Kickback has priority over the target transition. This matters in UP2 at n==P2: with `flick`=1 the next state is DN1, not DN2.
- `flick` is ignored in UP1, DN1, DN2, and in DN3 except at its final step.
- If `flick` is held high, the controller loops indefinitely. Examples: UP2 ↔ DN1 between 0 and P1; DN3 → UP1 restart. Both are legal and required.
- Overflow and underflow cannot occur in legal states. An illegal `state` encoding recovers to IDLE with level=0 on the next edge.

## Timing
- Reset, synchronous and sampled on `clk`: state=IDLE, level=0. Hence cmd=0 and busy=0 in the cycle after the reset edge.
- Reset mid-sequence: the controller returns to IDLE at the next edge. The datapath clears via its own reset, or via cmd=0 one cycle later at the latest, so the mirror stays coherent.
- Start latency: `flick` sampled high in IDLE at edge k → cmd=1 during cycle k+1. The first lamp appears in the datapath register at edge k+2.
- One lamp changes per clock while busy; there is no hold or stall.
- Nominal full sequence with no kickback is 56 busy cycles: UP1 6 + DN1 6 + UP2 11 + DN2 6 + UP3 11 + DN3 16.
- The datapath `lamp` output during a cycle shows the post-edge pattern (level±1). The register holds `level`.

## Test plan
- Reset: assert `rst` for 2 cycles mid-UP3 → state=IDLE, level=0, cmd=0, busy=0 next cycle. The datapath register reads 16'h0000 within 1 further cycle.
- Single-cycle `flick` in IDLE → busy for exactly 56 cycles, then IDLE. The datapath register reaches these values at each segment end:
  - 16'h003F after UP1
  - 16'h0000 after DN1
  - 16'h07FF after UP2
  - 16'h001F after DN2
  - 16'hFFFF after UP3
  - 16'h0000 after DN3
- Kickback in UP2: `flick` high only in the cycle where level goes 5→6 → next state DN1. Level goes 6→0, then UP2 restarts and completes normally.
- Kickback priority: in UP3, `flick` high on the 10→11 step → DN2. Level goes back down to 5, then UP3 re-runs. With `flick` high on the 10→11 step in UP2 → DN1, not DN2.
- `flick` held high continuously from IDLE → UP1, DN1, then an endless UP2 (0→6) / DN1 (6→0) loop. Level never exceeds 6. `cmd` is never 0 while busy.
- Restart: `flick` high on the last DN3 step (1→0) → UP1 on the next cycle with no IDLE cycle. Low at that step → IDLE, cmd=0.
